// File: rtl/line_buffer_3.sv
// Three-row vertical window over a raster pixel stream using two line memories (A = row r-1, B = row r-2).
// Optional LINEBUF_ZERO_FILL_EN: qualify rows 0/1 with zeroed history. Latency 1 cycle; no backpressure (pix_valid always accepted).
module line_buffer_3 #(
  parameter int IMG_WIDTH = 640,
  parameter int PIX_W     = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [PIX_W-1:0] line0,
  output logic [PIX_W-1:0] line1,
  output logic [PIX_W-1:0] line2,
  output logic             out_valid,
  output logic             eol
);

  localparam int               COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [1:0]       ROWS_MAX = 2'd2;

  logic [PIX_W-1:0] mem_a [IMG_WIDTH];
  logic [PIX_W-1:0] mem_b [IMG_WIDTH];

  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       rows_q, rows_d;
  logic [PIX_W-1:0] line0_q, line0_d;
  logic [PIX_W-1:0] line1_q, line1_d;
  logic [PIX_W-1:0] line2_q, line2_d;
  logic             out_valid_q, out_valid_d;
  logic             eol_q, eol_d;

  logic [COL_W-1:0] addr;
  logic [1:0]       cur_rows;
  logic             last_col;
  logic [PIX_W-1:0] rd_a;
  logic [PIX_W-1:0] rd_b;

  // sof relocates the pixel to (col 0, row 0) regardless of where the counters stand.
  always_comb begin
    addr     = sof ? '0 : col_q;
    cur_rows = sof ? 2'd0 : rows_q;
    last_col = (addr == LAST_COL);
    rd_a     = mem_a[addr];
    rd_b     = mem_b[addr];
  end

  always_comb begin
    col_d       = col_q;
    rows_d      = rows_q;
    line0_d     = line0_q;
    line1_d     = line1_q;
    line2_d     = line2_q;
    out_valid_d = 1'b0;
    eol_d       = 1'b0;
    if (pix_valid) begin
      col_d   = last_col ? '0 : addr + COL_W'(1);
      rows_d  = (last_col && (cur_rows != ROWS_MAX)) ? cur_rows + 2'd1 : cur_rows;
      line2_d = pix_in;
`ifdef LINEBUF_ZERO_FILL_EN
      // Rows above the frame top read as black rather than stale memory.
      line1_d     = (cur_rows == 2'd0)     ? '0 : rd_a;
      line0_d     = (cur_rows != ROWS_MAX) ? '0 : rd_b;
      out_valid_d = 1'b1;
`else
      line1_d     = rd_a;
      line0_d     = rd_b;
      out_valid_d = (cur_rows == ROWS_MAX);
`endif
      eol_d = out_valid_d && last_col;
    end
  end

  // Line memories are deliberately not reset; every location is rewritten before it is qualified.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      mem_a[addr] <= pix_in;
      mem_b[addr] <= rd_a;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q       <= '0;
      rows_q      <= 2'd0;
      line0_q     <= '0;
      line1_q     <= '0;
      line2_q     <= '0;
      out_valid_q <= 1'b0;
      eol_q       <= 1'b0;
    end else begin
      col_q       <= col_d;
      rows_q      <= rows_d;
      line0_q     <= line0_d;
      line1_q     <= line1_d;
      line2_q     <= line2_d;
      out_valid_q <= out_valid_d;
      eol_q       <= eol_d;
    end
  end

  assign line0     = line0_q;
  assign line1     = line1_q;
  assign line2     = line2_q;
  assign out_valid = out_valid_q;
  assign eol       = eol_q;

`ifndef SYNTHESIS
  a_eol_qualified: assert property (@(posedge clk) disable iff (!reset_n) eol |-> out_valid);
  a_rows_sat:      assert property (@(posedge clk) disable iff (!reset_n) rows_q != 2'd3);
  a_col_range:     assert property (@(posedge clk) disable iff (!reset_n) col_q <= LAST_COL);
`endif

endmodule

// File: tb/tb_line_buffer_3.sv
// Directed bench for line_buffer_3 at IMG_WIDTH=4; pixel value is 16*row+col.
module tb_line_buffer_3;

  localparam int W = 4;
  localparam int P = 24;
`ifdef LINEBUF_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [P-1:0] pix_in = '0;
  logic         pix_valid = 1'b0;
  logic         sof = 1'b0;
  logic [P-1:0] line0, line1, line2;
  logic         out_valid, eol;

  int checks = 0;
  int failures = 0;

  line_buffer_3 #(.IMG_WIDTH(W), .PIX_W(P)) dut (
    .clk(clk), .reset_n(reset_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .line0(line0), .line1(line1), .line2(line2), .out_valid(out_valid), .eol(eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sof;
    logic [P-1:0] pix;
    logic         eov;
    logic         eeol;
    logic         chkl;
    logic [P-1:0] e0;
    logic [P-1:0] e1;
    logic [P-1:0] e2;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic eov, input logic eeol, input logic chkl,
                         input logic [P-1:0] e0, input logic [P-1:0] e1, input logic [P-1:0] e2);
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(eov));
    chk({nm, ".eol"}, 32'(eol), 32'(eeol));
    chk({nm, ".line2"}, 32'(line2), 32'(e2));
    if (chkl) begin
      chk({nm, ".line0"}, 32'(line0), 32'(e0));
      chk({nm, ".line1"}, 32'(line1), 32'(e1));
    end
  endtask

  task automatic send_px(input string nm, input logic s, input logic [P-1:0] p,
                         input logic eov, input logic eeol, input logic chkl,
                         input logic [P-1:0] e0, input logic [P-1:0] e1, input logic [P-1:0] e2);
    @(negedge clk);
    pix_valid = 1'b1;
    sof       = s;
    pix_in    = p;
    @(posedge clk);
    #1;
    chk_out(nm, eov, eeol, chkl, e0, e1, e2);
  endtask

  // Idle cycle: outputs hold, qualifiers drop.
  task automatic gap(input string nm, input logic s, input logic [P-1:0] e0,
                     input logic [P-1:0] e1, input logic [P-1:0] e2);
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = s;
    pix_in    = 24'hABCDEF;
    @(posedge clk);
    #1;
    chk_out(nm, 1'b0, 1'b0, 1'b1, e0, e1, e2);
  endtask

  // Rows 0 and 1 of a frame; history is only defined when zero-fill is built in.
  task automatic early_rows(input string nm, input logic with_sof);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < W; c++) begin
        send_px($sformatf("%s.r%0dc%0d", nm, r, c), with_sof && (r == 0) && (c == 0),
                P'(16 * r + c), ZF, ZF && (c == W - 1), ZF,
                '0, (r == 1) ? P'(c) : '0, P'(16 * r + c));
      end
    end
  endtask

  task automatic row2_px(input string nm, input int c);
    send_px($sformatf("%s.r2c%0d", nm, c), 1'b0, P'(32 + c), 1'b1, c == W - 1, 1'b1,
            P'(c), P'(16 + c), P'(32 + c));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b1, '0, '0, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Continuous 3-row frame, sof on first pixel
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        tbl[r * W + c].sof  = (r == 0) && (c == 0);
        tbl[r * W + c].pix  = P'(16 * r + c);
        tbl[r * W + c].eov  = (r == 2) || ZF;
        tbl[r * W + c].eeol = ((r == 2) || ZF) && (c == W - 1);
        tbl[r * W + c].chkl = (r == 2) || ZF;
        tbl[r * W + c].e0   = (r == 2) ? P'(c) : '0;
        tbl[r * W + c].e1   = (r == 2) ? P'(16 + c) : ((r == 1) ? P'(c) : '0);
        tbl[r * W + c].e2   = P'(16 * r + c);
      end
    end
    for (int i = 0; i < 12; i++) begin
      send_px($sformatf("stream[%0d]", i), tbl[i].sof, tbl[i].pix, tbl[i].eov,
              tbl[i].eeol, tbl[i].chkl, tbl[i].e0, tbl[i].e1, tbl[i].e2);
    end

    // Row 2 with pix_valid toggling
    early_rows("gaps", 1'b1);
    for (int c = 0; c < W; c++) begin
      row2_px("gaps", c);
      gap($sformatf("gaps.hold%0d", c), 1'b0, P'(c), P'(16 + c), P'(32 + c));
    end

    // sof without pix_valid is ignored
    early_rows("sofidle", 1'b1);
    row2_px("sofidle", 0);
    gap("sofidle.gap", 1'b1, '0, 24'h10, 24'h20);
    for (int c = 1; c < W; c++) row2_px("sofidle", c);

    // sof mid-line at row 1 col 2 restarts the frame
    for (int c = 0; c < W; c++)
      send_px($sformatf("midsof.a%0d", c), c == 0, P'(c), ZF, ZF && (c == W - 1), ZF, '0, '0, P'(c));
    send_px("midsof.b0", 1'b0, 24'h10, ZF, 1'b0, ZF, '0, 24'h00, 24'h10);
    send_px("midsof.b1", 1'b0, 24'h11, ZF, 1'b0, ZF, '0, 24'h01, 24'h11);
    send_px("midsof.sof", 1'b1, 24'h55, ZF, 1'b0, ZF, '0, '0, 24'h55);
    for (int c = 1; c < W; c++)
      send_px($sformatf("midsof.r0c%0d", c), 1'b0, P'(c), ZF, ZF && (c == W - 1), ZF, '0, '0, P'(c));
    for (int c = 0; c < W; c++)
      send_px($sformatf("midsof.r1c%0d", c), 1'b0, P'(16 + c), ZF, ZF && (c == W - 1), ZF,
              '0, (c == 0) ? 24'h55 : P'(c), P'(16 + c));
    for (int c = 0; c < W; c++)
      send_px($sformatf("midsof.r2c%0d", c), 1'b0, P'(32 + c), 1'b1, c == W - 1, 1'b1,
              (c == 0) ? 24'h55 : P'(c), P'(16 + c), P'(32 + c));

    // Asynchronous reset in the middle of row 2
    early_rows("rst", 1'b1);
    row2_px("rst", 0);
    row2_px("rst", 1);
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk_out("rst.async", 1'b0, 1'b0, 1'b1, '0, '0, '0);
    @(negedge clk);
    reset_n = 1'b1;
    early_rows("postrst", 1'b0);
    for (int c = 0; c < W; c++) row2_px("postrst", c);

    @(negedge clk);
    pix_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/line_buffer_3.md
LINE_BUFFER_3 -- requirements
Module: line_buffer_3

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per image line (bench also runs 4).
REQ-002 Parameter PIX_W, default 24, pixel width (8-bit R/G/B packed 23:16/15:8/7:0).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pix_in  input  PIX_W  raster-order pixel stream.
REQ-006 pix_valid  input  1  pix_in valid this cycle; the block always accepts (no backpressure).
REQ-007 sof  input  1  start of frame; qualified by pix_valid; marks the first pixel of a frame.
REQ-008 line0  output  PIX_W  pixel from row r-2, same column.
REQ-009 line1  output  PIX_W  pixel from row r-1, same column.
REQ-010 line2  output  PIX_W  pixel from current row r (delayed pix_in).
REQ-011 out_valid  output  1  line0/1/2 form a valid vertical 3-pixel column.
REQ-012 eol  output  1  qualifies out_valid; column is last of line (col = IMG_WIDTH-1).

Function
REQ-013 Storage SHALL be two line memories, A (row r-1) and B (row r-2), IMG_WIDTH x PIX_W each.
REQ-014 Column counter col SHALL be ceil(log2(IMG_WIDTH)) bits; row counter rows SHALL saturate at 2.
REQ-015 On accepted pixel (pix_valid=1) at address a (a=0 if sof, else col): line2<=pix_in, line1<=A[a], line0<=B[a], A[a]<=pix_in, B[a]<=old A[a], in one cycle.
REQ-016 Latency SHALL be exactly 1 cycle from accepted pixel to registered outputs; no combinational path input->output.
REQ-017 col SHALL increment per accepted pixel; at IMG_WIDTH-1 it SHALL wrap to 0 and rows SHALL increment (saturating at 2).
REQ-018 sof with pix_valid SHALL force the pixel to col 0, rows 0 (stored at address 0; col becomes 1), overriding any mid-line position.
REQ-019 sof without pix_valid SHALL be ignored.
REQ-020 out_valid SHALL be 1 in the cycle after an accepted pixel whose rows value was 2, else 0.
REQ-021 eol SHALL be 1 exactly when out_valid is 1 and the pixel was at col IMG_WIDTH-1.
REQ-022 Cycles with pix_valid=0 SHALL hold line0/1/2, col, rows and memories; out_valid, eol SHALL drop to 0.
REQ-023 Outputs of rows 0-1 SHALL not be qualified (memory contents undefined).

Reset
REQ-024 reset_n=0 SHALL asynchronously clear col, rows, line0, line1, line2, out_valid, eol to 0.
REQ-025 Memories SHALL not be cleared by reset; contents are don't-care until rewritten.
REQ-026 Reset mid-frame SHALL abort the frame; the next accepted pixel is treated as col 0, row 0 regardless of sof.

Configuration
REQ-027 Macro LINEBUF_ZERO_FILL_EN selects edge handling.
REQ-028 Defined: out_valid SHALL also assert for rows 0 and 1; line0 (rows 0,1) and line1 (row 0) SHALL read 0 instead of memory.
REQ-029 Undefined: behaviour per REQ-020/REQ-023; no zero-fill logic present.

Verification (IMG_WIDTH=4, pixel value = 16*row+col)
REQ-030 Reset, stream 12 pixels continuous with sof on first -> out_valid high only for row 2 outputs; col 1 gives line0=0x01, line1=0x11, line2=0x21; eol on col 3.
REQ-031 Row 2 with pix_valid toggling 1/0 -> outputs and counters hold on gaps, out_valid pulses only after accepted pixels, same values as REQ-030.
REQ-032 sof asserted at row 1 col 2 -> that pixel stored at col 0, rows restarts; no out_valid until new row 2.
REQ-033 reset_n pulsed low mid-cycle in row 2 -> all outputs 0 immediately; next 8 pixels produce no out_valid.
REQ-034 LINEBUF_ZERO_FILL_EN defined, first pixel 0x00 -> out_valid=1, line0=0, line1=0, line2=0x00; row 1 col 0 -> line0=0, line1=0x00, line2=0x10.
REQ-035 sof=1 with pix_valid=0 at row 2 col 1 -> ignored; next accepted pixel continues at col 1.
